vga_frame_checker: RTL and testbench



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_sync_edge.sv | 21 ++
 rtl/vga_frame_checker.sv | 182 ++++++++++++++++++
 tb/tb_vga_frame_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package. The pixel generator and the frame checker both
// import it, so both ends use the same line and frame geometry.
package vga_pkg;

  // Nominal 50 MHz timing: clocks per line and lines per frame
  localparam int H_TOTAL     = 1586;
  localparam int V_TOTAL     = 526;

  // Active window, half-open ranges [start, end)
  localparam int H_ACT_START = 285;
  localparam int H_ACT_END   = 1555;
  localparam int V_ACT_START = 35;
  localparam int V_ACT_END   = 515;

  // Sync pulse widths: clocks for HS, lines for VS
  localparam int H_SYNC_W    = 190;
  localparam int V_SYNC_W    = 2;

  // Consecutive clean frames needed before the checker reports lock
  localparam int LOCK_FRAMES = 2;

  // Saturation limits of the receive-side position counters and lit accumulator
  localparam logic [10:0] CX_MAX  = 11'd2047;
  localparam logic [9:0]  CY_MAX  = 10'd1023;
  localparam logic [19:0] ACC_MAX = 20'hFFFFF;

  // Frame checker lock state
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags its high-to-low transition. The register
// resets low so a sync line that is already low at reset release is not
// mistaken for a falling edge.
module vga_sync_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sync,
  output logic fall
);

  logic sync_q;

  // Remember the previous sync level for edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= sync;
  end

  assign fall = ~sync & sync_q;

endmodule

// File: rtl/vga_frame_checker.sv
// Receive-side VGA timing checker. Rebuilds the beam position from the sync
// falling edges, measures line length and frame height, locks after a run of
// clean frames and counts lit clocks inside the active window every frame.
module vga_frame_checker #(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int H_ACT_START = vga_pkg::H_ACT_START,
  parameter int H_ACT_END   = vga_pkg::H_ACT_END,
  parameter int V_ACT_START = vga_pkg::V_ACT_START,
  parameter int V_ACT_END   = vga_pkg::V_ACT_END,
  parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [19:0] lit_count,
  output logic        frame_done
);

  import vga_pkg::*;

  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] rx_cx;
  logic [9:0]  rx_cy;
  logic [19:0] acc;
  logic        frame_bad;
  logic [7:0]  good_cnt;
  lock_state_t state;

  lock_state_t state_next;
  logic [7:0]  good_next;
  logic [11:0] cx_plus1;
  logic [10:0] cy_plus1;
  logic        hunting;
  logic        vs_frame;
  logic        line_bad;
  logic        frame_len_bad;
  logic        stray_vs;
  logic        cx_lost;
  logic        cy_lost;
  logic        frame_clean;
  logic        h_err_d;
  logic        v_err_d;
  logic        in_window;
  logic        acc_inc;

  vga_sync_edge u_hs_edge (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sync     (VGA_HS),
    .fall     (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .sync     (VGA_VS),
    .fall     (vs_fall)
  );

  // Classify the current edges and decide the next lock state
  always_comb begin
    state_next    = state;
    good_next     = good_cnt;
    hunting       = (state == SEARCH);
    cx_plus1      = {1'b0, rx_cx} + 12'd1;
    cy_plus1      = {1'b0, rx_cy} + 11'd1;
    vs_frame      = vs_fall && hs_fall;
    line_bad      = hs_fall && !hunting && (cx_plus1 != 12'(H_TOTAL));
    frame_len_bad = vs_frame && !hunting && (cy_plus1 != 11'(V_TOTAL));
    stray_vs      = vs_fall && !hs_fall && !hunting;
    cx_lost       = !hs_fall && (rx_cx == CX_MAX - 11'd1) && !hunting;
    cy_lost       = hs_fall && !vs_fall && (rx_cy == CY_MAX - 10'd1) && !hunting;
    frame_clean   = vs_frame && !frame_bad && !line_bad && (cy_plus1 == 11'(V_TOTAL));
    h_err_d       = line_bad || cx_lost;
    v_err_d       = frame_len_bad || cy_lost || stray_vs;
    in_window     = (rx_cx >= 11'(H_ACT_START)) && (rx_cx < 11'(H_ACT_END)) &&
                    (rx_cy >= 10'(V_ACT_START)) && (rx_cy < 10'(V_ACT_END));
    acc_inc       = !hunting && in_window && ((VGA_R | VGA_G | VGA_B) != 4'd0);

    if (cx_lost || cy_lost || stray_vs) begin
      state_next = SEARCH;
      good_next  = 8'd0;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_frame) begin
            state_next = ACQUIRE;
            good_next  = 8'd0;
          end
        end
        ACQUIRE: begin
          if (vs_frame) begin
            if (!frame_clean) begin
              good_next = 8'd0;
            end else if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) begin
              state_next = LOCKED;
              good_next  = 8'd0;
            end else begin
              good_next = good_cnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (h_err_d || v_err_d) begin
            state_next = ACQUIRE;
            good_next  = 8'd0;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = 8'd0;
        end
      endcase
    end
  end

  // Beam position rebuilt from sync edges, both counters saturate when sync is lost
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_cx <= 11'd0;
      rx_cy <= 10'd0;
    end else begin
      if (hs_fall)              rx_cx <= 11'd0;
      else if (rx_cx != CX_MAX) rx_cx <= rx_cx + 11'd1;
      if (vs_fall)                          rx_cy <= 10'd0;
      else if (hs_fall && rx_cy != CY_MAX)  rx_cy <= rx_cy + 10'd1;
    end
  end

  // Lock FSM, clean-frame counter and the sticky bad-line flag for the current frame
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      good_cnt  <= 8'd0;
      frame_bad <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      if (vs_fall)       frame_bad <= 1'b0;
      else if (line_bad) frame_bad <= 1'b1;
    end
  end

  // Registered results: error pulses, measurements and the per-frame lit count
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_done  <= 1'b0;
      line_len    <= 11'd0;
      frame_lines <= 10'd0;
      lit_count   <= 20'd0;
      acc         <= 20'd0;
    end else begin
      locked     <= (state_next == LOCKED);
      h_err      <= h_err_d;
      v_err      <= v_err_d;
      frame_done <= vs_frame;
      if (hs_fall) line_len <= cx_plus1[11] ? CX_MAX : cx_plus1[10:0];
      if (vs_frame) begin
        frame_lines <= cy_plus1[10] ? CY_MAX : cy_plus1[9:0];
        lit_count   <= acc;
        acc         <= 20'd0;
      end else if (acc_inc && acc != ACC_MAX) begin
        acc <= acc + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Scoreboard bench for vga_frame_checker using a shrunken 40x12 timing so that
// a whole frame is 480 clocks. Expected frame results are queued as frames are
// driven and checked by a monitor whenever frame_done pulses.
module tb_vga_frame_checker;

  localparam int HT  = 40;
  localparam int VT  = 12;
  localparam int HAS = 10;
  localparam int HAE = 30;
  localparam int VAS = 3;
  localparam int VAE = 9;
  localparam int HSW = 4;
  localparam int VSW = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS;
  logic        locked, h_err, v_err, frame_done;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [19:0] lit_count;

  typedef struct { int lines; int lit; } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int herr_cnt = 0, verr_cnt = 0, fd_cnt = 0, lock_rise_cnt = 0;
  int herr_cyc = -1, verr_cyc = -1, lock_rise_cyc = -1, lock_fall_cyc = -1;
  int herr_len = -1;
  bit locked_prev = 1'b0;
  int vs_starts = 0;
  int vs_cyc [0:31];
  int last_hs_cyc = 0, bad_hs_cyc = -1, stray_cyc = -1;

  vga_frame_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_ACT_START(VAS), .V_ACT_END(VAE), .LOCK_FRAMES(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .locked(locked), .h_err(h_err), .v_err(v_err),
    .line_len(line_len), .frame_lines(frame_lines),
    .lit_count(lit_count), .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int lines, input int lit);
    exp_t e;
    e.lines = lines;
    e.lit   = lit;
    sb_q.push_back(e);
  endtask

  task automatic driveIdle(input logic hs, input logic vs, input int n);
    for (int i = 0; i < n; i++) begin
      VGA_HS = hs; VGA_VS = vs;
      VGA_R = 4'd0; VGA_G = 4'd0; VGA_B = 4'd0;
      @(posedge CLOCK_50); #1;
    end
  endtask

  // pat: 0 black, 1 blue everywhere, 2 green on even lines.
  // short_line: that line is one clock short. stray_line: VS drops 10 clocks into it.
  task automatic applyStimulus(input int pat, input int short_line,
                               input int stray_line, input int nlines);
    for (int gy = 0; gy < nlines; gy++) begin
      int len;
      len = (gy == short_line) ? HT - 1 : HT;
      for (int gx = 0; gx < len; gx++) begin
        VGA_HS = (gx < HSW) ? 1'b0 : 1'b1;
        VGA_VS = (gy < VSW) ? 1'b0 : 1'b1;
        if (gy == stray_line && gx >= 10 && gx < 14) VGA_VS = 1'b0;
        VGA_R = 4'd0;
        VGA_G = (pat == 2 && (gy % 2) == 0) ? 4'h3 : 4'h0;
        VGA_B = (pat == 1) ? 4'h8 : 4'h0;
        if (gx == 0) begin
          last_hs_cyc = cyc;
          if (gy == short_line + 1 && short_line >= 0) bad_hs_cyc = cyc;
          if (gy == 0) begin
            vs_starts++;
            vs_cyc[vs_starts] = cyc;
          end
        end
        if (gy == stray_line && gx == 10) stray_cyc = cyc;
        @(posedge CLOCK_50); #1;
      end
    end
  endtask

  // Monitor: record pulses and lock edges, and check frame results against the scoreboard
  always @(negedge CLOCK_50) begin
    if (h_err) begin herr_cnt++; herr_cyc = cyc; herr_len = int'(line_len); end
    if (v_err) begin verr_cnt++; verr_cyc = cyc; end
    if (locked && !locked_prev) begin lock_rise_cnt++; lock_rise_cyc = cyc; end
    if (!locked && locked_prev) lock_fall_cyc = cyc;
    locked_prev = locked;
    if (frame_done) begin
      fd_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame_done: frame_done=1, expected none queued (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("frame_lines", int'(frame_lines), e.lines);
        checkOutput("lit_count", int'(lit_count), e.lit);
      end
    end
  end

  initial begin
    int hs_ref, herr_snap, verr_snap, fd_snap;
    reset = 1'b1;
    VGA_HS = 1'b1; VGA_VS = 1'b1;
    VGA_R = 4'd0; VGA_G = 4'd0; VGA_B = 4'd0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_h_err", int'(h_err), 0);
    checkOutput("rst_v_err", int'(v_err), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_line_len", int'(line_len), 0);
    checkOutput("rst_frame_lines", int'(frame_lines), 0);
    checkOutput("rst_lit_count", int'(lit_count), 0);
    reset = 1'b0;
    driveIdle(1'b1, 1'b1, 5);

    $display("[TB] nominal acquisition");
    pushExp(1, 0);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    checkOutput("lock_rise_count", lock_rise_cnt, 1);
    checkOutput("lock_rise_cycle", lock_rise_cyc, vs_cyc[3] + 1);
    applyStimulus(2, -1, -1, VT); pushExp(VT, 60);
    applyStimulus(0, -1, -1, VT); pushExp(VT, 0);
    checkOutput("nominal_h_err_count", herr_cnt, 0);
    checkOutput("nominal_v_err_count", verr_cnt, 0);
    checkOutput("nominal_line_len", int'(line_len), HT);
    checkOutput("nominal_frame_lines", int'(frame_lines), VT);
    checkOutput("nominal_locked", int'(locked), 1);

    $display("[TB] short line while locked");
    applyStimulus(1, 5, -1, VT); pushExp(VT, 120);
    checkOutput("short_h_err_count", herr_cnt, 1);
    checkOutput("short_h_err_cycle", herr_cyc, bad_hs_cyc + 1);
    checkOutput("short_unlock_cycle", lock_fall_cyc, herr_cyc);
    checkOutput("short_line_len", herr_len, HT - 1);
    checkOutput("short_locked", int'(locked), 0);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);

    $display("[TB] stray VS while locked");
    applyStimulus(1, -1, 5, VT); pushExp(7, 40);
    checkOutput("relock_count", lock_rise_cnt, 2);
    checkOutput("relock_cycle", lock_rise_cyc, vs_cyc[9] + 1);
    checkOutput("stray_v_err_count", verr_cnt, 1);
    checkOutput("stray_v_err_cycle", verr_cyc, stray_cyc + 1);
    checkOutput("stray_unlock_cycle", lock_fall_cyc, verr_cyc);
    checkOutput("stray_locked", int'(locked), 0);
    checkOutput("stray_h_err_count", herr_cnt, 1);

    $display("[TB] HS lost while locked");
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT);
    hs_ref = last_hs_cyc;
    driveIdle(1'b1, 1'b1, 2100);
    checkOutput("hs_lost_lock_count", lock_rise_cnt, 3);
    checkOutput("hs_lost_h_err_count", herr_cnt, 2);
    checkOutput("hs_lost_h_err_cycle", herr_cyc, hs_ref + 2048);
    checkOutput("hs_lost_unlock_cycle", lock_fall_cyc, herr_cyc);
    checkOutput("hs_lost_locked", int'(locked), 0);
    checkOutput("hs_lost_v_err_count", verr_cnt, 1);
    pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, 6);
    checkOutput("pre_reset_locked", int'(locked), 1);
    checkOutput("pre_reset_lock_count", lock_rise_cnt, 4);

    $display("[TB] mid-frame reset with sync low");
    VGA_HS = 1'b0; VGA_VS = 1'b0;
    VGA_R = 4'd0; VGA_G = 4'd0; VGA_B = 4'd0;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_locked", int'(locked), 0);
    checkOutput("async_rst_line_len", int'(line_len), 0);
    checkOutput("async_rst_frame_lines", int'(frame_lines), 0);
    checkOutput("async_rst_lit_count", int'(lit_count), 0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    herr_snap = herr_cnt; verr_snap = verr_cnt; fd_snap = fd_cnt;
    reset = 1'b0;
    repeat (4) begin @(posedge CLOCK_50); #1; end
    checkOutput("release_h_err_count", herr_cnt, herr_snap);
    checkOutput("release_v_err_count", verr_cnt, verr_snap);
    checkOutput("release_frame_done_count", fd_cnt, fd_snap);
    checkOutput("release_line_len", int'(line_len), 0);
    checkOutput("release_locked", int'(locked), 0);
    driveIdle(1'b1, 1'b1, 5);
    pushExp(1, 0);
    applyStimulus(1, -1, -1, VT); pushExp(VT, 120);
    applyStimulus(1, -1, -1, 1);
    driveIdle(1'b1, 1'b1, 3);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    checkOutput("final_h_err_count", herr_cnt, 2);
    checkOutput("final_v_err_count", verr_cnt, 1);
    checkOutput("final_locked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
